rx_iq_buffer: RTL and testbench

RX_IQ_BUFFER -- requirements
Module: rx_iq_buffer

---
 rtl/rx_iq_buffer.sv | 117 +++++++++++
 tb/tb_rx_iq_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_iq_buffer
// Brief    : Synchronises the decimator strobe and queues 4x32-bit IQ entries
//            in a small circular buffer that the bus interface pops.
// Revision : 1.0 - initial release
// ============================================================================
module rx_iq_buffer #(
  parameter int DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic signed [31:0] RX1_I,
  input  logic signed [31:0] RX1_Q,
  input  logic signed [31:0] RX2_I,
  input  logic signed [31:0] RX2_Q,
  input  logic               IQ_valid,
  input  logic               rd_req,
  input  logic               flush,
  output logic [31:0]        OUT_RX1_I,
  output logic [31:0]        OUT_RX1_Q,
  output logic [31:0]        OUT_RX2_I,
  output logic [31:0]        OUT_RX2_Q,
  output logic               rd_valid,
  output logic               rd_underrun,
  output logic [4:0]         fill_level,
  output logic [15:0]        overflow_cnt
);

  localparam int                 c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [4:0]         c_DEPTH   = 5'(DEPTH);

  logic               r_sync1, r_sync2, r_sync3;
  logic [1:0]         r_live;
  logic               r_armed;
  logic [c_PTR_W-1:0] r_head, r_tail;
  logic [4:0]         r_fill;
  logic [15:0]        r_ovf;
  logic [127:0]       r_out;
  logic               r_rd_valid, r_rd_underrun;
  logic [127:0]       r_mem [DEPTH];

  logic w_wr_strobe, w_full, w_empty, w_do_wr, w_do_rd, w_drop;

  // r_live marks when r_sync2 holds a post-reset sample; the edge detector is
  // armed only after IQ_valid has been seen low, so a level held through reset
  // release never looks like a new sample.
  assign w_wr_strobe = r_armed & r_sync2 & ~r_sync3;
  assign w_full      = (r_fill == c_DEPTH);
  assign w_empty     = (r_fill == 5'd0);
  assign w_do_wr     = w_wr_strobe & (~w_full | rd_req) & ~flush;
  assign w_do_rd     = rd_req & ~w_empty & ~flush;
  assign w_drop      = w_wr_strobe & w_full & ~rd_req & ~flush;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= IQ_valid;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_live  <= {r_live[0], 1'b1};
      if (r_live[1] && !r_sync2) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_do_wr) r_mem[r_head] <= {RX1_I, RX1_Q, RX2_I, RX2_Q};
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_fill        <= 5'd0;
      r_ovf         <= 16'd0;
      r_out         <= 128'd0;
      r_rd_valid    <= 1'b0;
      r_rd_underrun <= 1'b0;
    end else if (flush) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_fill        <= 5'd0;
      r_ovf         <= 16'd0;
      r_rd_valid    <= 1'b0;
      r_rd_underrun <= 1'b0;
    end else begin
      r_rd_valid    <= rd_req;
      r_rd_underrun <= rd_req & w_empty;
      if (rd_req) r_out <= w_empty ? 128'd0 : r_mem[r_tail];
      if (w_do_wr) r_head <= r_head + c_PTR_ONE;
      if (w_do_rd) r_tail <= r_tail + c_PTR_ONE;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_fill <= r_fill + 5'd1;
        2'b01:   r_fill <= r_fill - 5'd1;
        default: r_fill <= r_fill;
      endcase
      if (w_drop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
    end
  end

  assign OUT_RX1_I    = r_out[127:96];
  assign OUT_RX1_Q    = r_out[95:64];
  assign OUT_RX2_I    = r_out[63:32];
  assign OUT_RX2_Q    = r_out[31:0];
  assign rd_valid     = r_rd_valid;
  assign rd_underrun  = r_rd_underrun;
  assign fill_level   = r_fill;
  assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rx_iq_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_iq_buffer
// Brief    : Directed self-checking bench for rx_iq_buffer (DEPTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_iq_buffer;

  logic               clk_in = 1'b0;
  logic               reset = 1'b0;
  logic signed [31:0] RX1_I = '0, RX1_Q = '0, RX2_I = '0, RX2_Q = '0;
  logic               IQ_valid = 1'b0, rd_req = 1'b0, flush = 1'b0;
  logic [31:0]        OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q;
  logic               rd_valid, rd_underrun;
  logic [4:0]         fill_level;
  logic [15:0]        overflow_cnt;
  logic [127:0]       out_all;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  rx_iq_buffer #(.DEPTH(8)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .RX1_I       (RX1_I),
    .RX1_Q       (RX1_Q),
    .RX2_I       (RX2_I),
    .RX2_Q       (RX2_Q),
    .IQ_valid    (IQ_valid),
    .rd_req      (rd_req),
    .flush       (flush),
    .OUT_RX1_I   (OUT_RX1_I),
    .OUT_RX1_Q   (OUT_RX1_Q),
    .OUT_RX2_I   (OUT_RX2_I),
    .OUT_RX2_Q   (OUT_RX2_Q),
    .rd_valid    (rd_valid),
    .rd_underrun (rd_underrun),
    .fill_level  (fill_level),
    .overflow_cnt(overflow_cnt)
  );

  assign out_all = {OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q};

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  function automatic logic [127:0] pat(input int v);
    return {32'(v), 32'(v + 1000), 32'(v + 2000), 32'(v + 3000)};
  endfunction

  // Rising edge at a negedge; the write lands on the 3rd posedge, which is
  // also where an optional pop/flush is sampled.
  task automatic iq_pulse(input logic [127:0] d, input logic pop, input logic fl,
                          output logic v, output logic u);
    {RX1_I, RX1_Q, RX2_I, RX2_Q} = d;
    IQ_valid = 1'b1;
    tick(); tick();
    IQ_valid = 1'b0;
    rd_req = pop;
    flush = fl;
    tick();
    v = rd_valid;
    u = rd_underrun;
    rd_req = 1'b0;
    flush = 1'b0;
    tick();
  endtask

  task automatic pop(output logic v, output logic u);
    rd_req = 1'b1;
    tick();
    v = rd_valid;
    u = rd_underrun;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  logic v, u;

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst_fill", 128'(fill_level), 128'd0);
    check("rst_ovf", 128'(overflow_cnt), 128'd0);
    check("rst_out", out_all, 128'd0);
    check("rst_valid", 128'({rd_valid, rd_underrun}), 128'd0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();

    // Single sample
    {RX1_I, RX1_Q, RX2_I, RX2_Q} = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    IQ_valid = 1'b1;
    tick(); tick();
    check("single_fill_pre", 128'(fill_level), 128'd0);
    IQ_valid = 1'b0;
    tick();
    check("single_fill_wr", 128'(fill_level), 128'd1);
    tick(); tick(); tick();
    check("single_valid_idle", 128'(rd_valid), 128'd0);
    pop(v, u);
    check("single_rd_valid", 128'(v), 128'd1);
    check("single_underrun", 128'(u), 128'd0);
    check("single_data", out_all,
          {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    check("single_fill_post", 128'(fill_level), 128'd0);
    check("single_valid_done", 128'(rd_valid), 128'd0);

    // Overflow: 10 samples into 8 slots
    do_reset();
    for (int i = 1; i <= 10; i++) iq_pulse(pat(i), 1'b0, 1'b0, v, u);
    check("ovf_fill", 128'(fill_level), 128'd8);
    check("ovf_cnt", 128'(overflow_cnt), 128'd2);
    for (int i = 1; i <= 8; i++) begin
      pop(v, u);
      check($sformatf("ovf_pop%0d", i), out_all, pat(i));
      check($sformatf("ovf_pop%0d_v", i), 128'({v, u}), 128'b10);
    end
    pop(v, u);
    check("ovf_pop9_data", out_all, 128'd0);
    check("ovf_pop9_flags", 128'({v, u}), 128'b11);
    check("ovf_cnt_hold", 128'(overflow_cnt), 128'd2);

    // Wrap-around: 20 write/pop pairs
    do_reset();
    for (int i = 0; i < 20; i++) begin
      iq_pulse(pat(32'h500 + i), 1'b0, 1'b0, v, u);
      check($sformatf("wrap_fill_w%0d", i), 128'(fill_level), 128'd1);
      pop(v, u);
      check($sformatf("wrap_data%0d", i), out_all, pat(32'h500 + i));
      check($sformatf("wrap_fill_r%0d", i), 128'(fill_level), 128'd0);
    end

    // Full plus simultaneous write and pop
    do_reset();
    for (int i = 0; i < 8; i++) iq_pulse(pat(32'hA0 + i), 1'b0, 1'b0, v, u);
    check("full_fill", 128'(fill_level), 128'd8);
    iq_pulse(pat(32'hB0), 1'b1, 1'b0, v, u);
    check("full_rw_data", out_all, pat(32'hA0));
    check("full_rw_flags", 128'({v, u}), 128'b10);
    check("full_rw_fill", 128'(fill_level), 128'd8);
    check("full_rw_ovf", 128'(overflow_cnt), 128'd0);
    for (int i = 1; i < 8; i++) pop(v, u);
    check("full_rw_a7", out_all, pat(32'hA7));
    pop(v, u);
    check("full_rw_new", out_all, pat(32'hB0));

    // Flush priority
    do_reset();
    for (int i = 0; i < 6; i++) iq_pulse(pat(32'hC0 + i), 1'b0, 1'b0, v, u);
    pop(v, u);
    check("flush_pre_fill", 128'(fill_level), 128'd5);
    iq_pulse(pat(32'hD0), 1'b1, 1'b1, v, u);
    check("flush_no_valid", 128'(v), 128'd0);
    check("flush_fill", 128'(fill_level), 128'd0);
    check("flush_ovf", 128'(overflow_cnt), 128'd0);
    check("flush_out_held", out_all, pat(32'hC0));
    pop(v, u);
    check("flush_empty_pop", 128'({v, u}), 128'b11);

    // Reset mid-stream with IQ_valid held high
    do_reset();
    for (int i = 0; i < 3; i++) iq_pulse(pat(32'hE0 + i), 1'b0, 1'b0, v, u);
    pop(v, u);
    check("mid_pre_out", out_all, pat(32'hE0));
    {RX1_I, RX1_Q, RX2_I, RX2_Q} = pat(32'hF0);
    IQ_valid = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_out", out_all, 128'd0);
    check("mid_rst_fill", 128'(fill_level), 128'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_hold_fill", 128'(fill_level), 128'd0);
    check("mid_hold_misc", 128'({overflow_cnt, rd_valid, rd_underrun}), 128'd0);
    IQ_valid = 1'b0;
    tick(); tick();
    IQ_valid = 1'b1;
    tick(); tick();
    check("mid_rise_pre", 128'(fill_level), 128'd0);
    tick(); tick();
    check("mid_rise_wr", 128'(fill_level), 128'd1);
    IQ_valid = 1'b0;
    pop(v, u);
    check("mid_rise_data", out_all, pat(32'hF0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
